// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit for the memory stage.
//
// Accepts one datapath request at a time, checks alignment and bounds,
// issues a row-aligned access with byte enables to a handshaked data
// memory, waits for the response (with a watchdog) and returns
// extended load data or an exception code.
//
// Handshake semantics (all channels): a transfer happens on a rising
// clock edge where valid and ready are both 1. Once a producer raises
// valid it holds valid and its payload stable until that edge.
// On the memory request channel mem_req_o plays "valid" and mem_gnt_i
// plays "ready".
//
// Ports:
//   clk, resetn              clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o  datapath request handshake
//   req_addr_i, req_size_i   byte address, size (0=B,1=H,2=W,3=D)
//   req_unsigned_i, req_wr_i zero-extend loads, store select
//   req_wr_data_i            right-justified store data
//   mem_req_o/mem_gnt_i      memory request handshake
//   mem_addr_o, mem_wr_o     row address ([2:0]=0), write select
//   mem_be_o, mem_wr_data_o  byte enables, lane-shifted store data
//   mem_rvalid_i, mem_rdata_i, mem_err_i  memory response
//   resp_valid_o/resp_ready_i response handshake
//   resp_rd_data_o           extended load data (0 for stores/exceptions)
//   exc_valid_o, exc_code_o  exception flag and cause
//   dbg_state_o              current FSM state (0=IDLE 1=ISSUE 2=WAIT 3=RESP)
module mem_lsu #(
  parameter int          ADDR_W   = 64,
  parameter logic [63:0] MEM_BASE = 64'd0,
  parameter logic [63:0] MEM_SIZE = 64'd524288,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic              req_wr_i,
  input  logic [63:0]       req_wr_data_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_be_o,
  output logic [63:0]       mem_wr_data_o,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i,
  input  logic              mem_err_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [63:0]       resp_rd_data_o,
  output logic              exc_valid_o,
  output logic [4:0]        exc_code_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // Bounds arithmetic is one bit wider than the address so that a request
  // whose end wraps past the top of the address space is out of bounds.
  localparam int AXW = ADDR_W + 1;
  localparam logic [AXW-1:0] BASE_X  = AXW'(MEM_BASE);
  localparam logic [AXW-1:0] LIMIT_X = AXW'(MEM_BASE) + AXW'(MEM_SIZE);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q, wr_q, exc_q;
  logic [7:0]        be_q;
  logic [63:0]       wd_q, rd_q;
  logic [4:0]        code_q;
  logic [31:0]       cnt_q;

  // Request checks, evaluated combinationally on the incoming request.
  logic           misal, oob;
  logic [AXW-1:0] addr_x, size_x;
  logic [7:0]     mask;
  always_comb begin
    misal  = 1'b0;
    mask   = 8'h01;
    size_x = '0;
    case (req_size_i)
      2'd0: begin misal = 1'b0;               mask = 8'h01; end
      2'd1: begin misal = req_addr_i[0];      mask = 8'h03; end
      2'd2: begin misal = |req_addr_i[1:0];   mask = 8'h0F; end
      default: begin misal = |req_addr_i[2:0]; mask = 8'hFF; end
    endcase
    size_x[3:0] = 4'd1 << req_size_i;
    addr_x      = {1'b0, req_addr_i};
    oob         = (addr_x < BASE_X) || ((addr_x + size_x) > LIMIT_X);
  end

  // Load extraction from the captured row.
  logic [63:0] sh, ld;
  always_comb begin
    sh = mem_rdata_i >> {addr_q[2:0], 3'b000};
    ld = sh;
    case (size_q)
      2'd0: ld = uns_q ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1: ld = uns_q ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2: ld = uns_q ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ld = sh;
    endcase
  end

  // The watchdog fires on the last cycle of the TIMEOUT-cycle budget so
  // that ISSUE+WAIT occupy exactly TIMEOUT cycles.
  logic tmo_hit;
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q >= 32'(TIMEOUT - 1));

  logic accept, take_rsp, tmo_fault;
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    take_rsp  = 1'b0;
    tmo_fault = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        accept  = 1'b1;
        state_d = (misal || oob) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_gnt_i) state_d = S_WAIT;
        else if (tmo_hit) begin
          state_d   = S_RESP;
          tmo_fault = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d  = S_RESP;
          take_rsp = 1'b1;
        end else if (tmo_hit) begin
          state_d   = S_RESP;
          tmo_fault = 1'b1;
        end
      end
      default: if (resp_ready_i) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      size_q <= '0;
      uns_q  <= 1'b0;
      wr_q   <= 1'b0;
      be_q   <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      exc_q  <= 1'b0;
      code_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) cnt_q <= '0;
      else if (state_q == S_ISSUE || state_q == S_WAIT) cnt_q <= cnt_q + 32'd1;

      if (accept) begin
        addr_q <= req_addr_i;
        size_q <= req_size_i;
        uns_q  <= req_unsigned_i;
        wr_q   <= req_wr_i;
        be_q   <= mask << req_addr_i[2:0];
        wd_q   <= req_wr_i ? (req_wr_data_i << {req_addr_i[2:0], 3'b000}) : 64'd0;
        rd_q   <= '0;
        exc_q  <= misal || oob;
        // Cause = {1, store, access_fault}: 4/6 misaligned, 5/7 fault.
        code_q <= (misal || oob) ? {2'b00, 1'b1, req_wr_i, ~misal} : 5'd0;
      end else if (take_rsp) begin
        if (mem_err_i) begin
          rd_q   <= '0;
          exc_q  <= 1'b1;
          code_q <= {2'b00, 1'b1, wr_q, 1'b1};
        end else begin
          rd_q <= wr_q ? 64'd0 : ld;
        end
      end else if (tmo_fault) begin
        rd_q   <= '0;
        exc_q  <= 1'b1;
        code_q <= {2'b00, 1'b1, wr_q, 1'b1};
      end
    end
  end

  // Outputs decoded from state plus registered fields; zero outside
  // their owning state so reset values fall out of state_q == S_IDLE.
  logic in_issue, in_resp;
  assign in_issue       = (state_q == S_ISSUE);
  assign in_resp        = (state_q == S_RESP);
  assign req_ready_o    = (state_q == S_IDLE);
  assign mem_req_o      = in_issue;
  assign mem_addr_o     = in_issue ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wr_o       = in_issue & wr_q;
  assign mem_be_o       = in_issue ? be_q : 8'd0;
  assign mem_wr_data_o  = in_issue ? wd_q : 64'd0;
  assign resp_valid_o   = in_resp;
  assign resp_rd_data_o = in_resp ? rd_q : 64'd0;
  assign exc_valid_o    = in_resp & exc_q;
  assign exc_code_o     = in_resp ? code_q : 5'd0;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus lightly randomised bench for mem_lsu. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_mem_lsu;
  localparam logic [63:0] BASE = 64'd0;
  localparam logic [63:0] SIZE = 64'd524288;
  localparam int          TMO  = 10;
  localparam int          W    = 70; // {exc_valid, exc_code[4:0], rd_data[63:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_unsigned = 1'b0, req_wr = 1'b0;
  logic [63:0] req_addr = '0, req_wr_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0, resp_ready = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        req_ready_o, mem_req_o, mem_wr_o, resp_valid_o, exc_valid_o;
  logic [63:0] mem_addr_o, mem_wr_data_o, resp_rd_data_o;
  logic [7:0]  mem_be_o;
  logic [4:0]  exc_code_o;
  logic [1:0]  dbg_state_o;

  mem_lsu #(.ADDR_W(64), .MEM_BASE(BASE), .MEM_SIZE(SIZE), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned), .req_wr_i(req_wr), .req_wr_data_i(req_wr_data),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr_o),
    .mem_wr_o(mem_wr_o), .mem_be_o(mem_be_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_rd_data_o(resp_rd_data_o), .exc_valid_o(exc_valid_o),
    .exc_code_o(exc_code_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-oriented, written from the behavioural description.
  function automatic logic [W-1:0] model_resp(input logic [63:0] addr, input logic [1:0] size,
                                               input logic uns, input logic wr,
                                               input logic [63:0] rdata, input logic err,
                                               input logic tmo);
    int n, idx;
    logic [64:0] a65;
    logic [63:0] v;
    n   = 1 << size;
    idx = int'(addr[2:0]);
    a65 = {1'b0, addr};
    if ((addr % 64'(n)) != 64'd0) return {1'b1, (wr ? 5'd6 : 5'd4), 64'd0};
    if ((a65 < {1'b0, BASE}) || ((a65 + 65'(n)) > ({1'b0, BASE} + {1'b0, SIZE})))
      return {1'b1, (wr ? 5'd7 : 5'd5), 64'd0};
    if (err || tmo) return {1'b1, (wr ? 5'd7 : 5'd5), 64'd0};
    if (wr) return '0;
    v = '0;
    for (int b = 0; b < 8; b++)
      if (b < n && idx + b < 8) v[8*b +: 8] = rdata[8*(idx+b) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int b = 0; b < 8; b++) if (b >= n) v[8*b +: 8] = 8'hFF;
    return {1'b0, 5'd0, v};
  endfunction

  function automatic logic [7:0] model_be(input logic [63:0] addr, input logic [1:0] size);
    logic [7:0] be;
    be = '0;
    for (int b = 0; b < 8; b++) if (b < (1 << size) && int'(addr[2:0]) + b < 8) be[int'(addr[2:0]) + b] = 1'b1;
    return be;
  endfunction

  function automatic logic [63:0] model_wd(input logic [63:0] addr, input logic wr, input logic [63:0] wdata);
    logic [63:0] wd;
    wd = '0;
    if (wr)
      for (int b = 0; b < 8; b++) if (int'(addr[2:0]) + b < 8) wd[8*(int'(addr[2:0])+b) +: 8] = wdata[8*b +: 8];
    return wd;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with the unit idle. gnt_dly: ISSUE cycles before
  // grant; rv_dly (>=1): WAIT cycles up to and including rvalid; rr_dly:
  // RESP cycles with resp_ready low; no_gnt: never grant (timeout).
  task automatic run_txn(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                         input logic wr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic err, input int gnt_dly, input int rv_dly,
                         input int rr_dly, input logic no_gnt);
    logic [W-1:0] pre, exp_r, got_r;
    int n_req;
    pre = model_resp(addr, size, uns, wr, rdata, 1'b0, 1'b0);
    exp_q.push_back(model_resp(addr, size, uns, wr, rdata, err, no_gnt));
    check("idle_req_ready", W'(req_ready_o), W'(1));
    req_valid = 1'b1; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wr = wr; req_wr_data = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wr_data = {$urandom, $urandom};
    if (pre[W-1]) begin
      check("exc_no_mem_req", W'(mem_req_o), W'(0));
    end else if (no_gnt) begin
      n_req = 0;
      for (int i = 0; i < 4 * TMO && mem_req_o; i++) begin
        n_req++;
        @(negedge clk);
      end
      check("timeout_req_cycles", W'(n_req), W'(TMO));
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check("issue_req", W'(mem_req_o), W'(1));
        check("issue_addr", W'(mem_addr_o), W'({addr[63:3], 3'b000}));
        check("issue_wr", W'(mem_wr_o), W'(wr));
        check("issue_be", W'(mem_be_o), W'(model_be(addr, size)));
        check("issue_wdata", W'(mem_wr_data_o), W'(model_wd(addr, wr, wdata)));
        check("issue_req_ready", W'(req_ready_o), W'(0));
        mem_gnt = (i == gnt_dly);
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      for (int j = 1; j <= rv_dly; j++) begin
        check("wait_no_req", W'(mem_req_o), W'(0));
        check("wait_no_resp", W'(resp_valid_o), W'(0));
        if (j == rv_dly) begin
          mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
        end
        @(negedge clk);
      end
      mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = {$urandom, $urandom};
    end
    check("resp_valid", W'(resp_valid_o), W'(1));
    if (exp_q.size() == 0) begin
      exp_r = '1;
      check("scoreboard_empty", W'(exp_q.size()), W'(1));
    end else begin
      exp_r = exp_q.pop_front();
    end
    for (int k = 0; k <= rr_dly; k++) begin
      got_r = {exc_valid_o, exc_code_o, resp_rd_data_o};
      check("resp_payload", got_r, exp_r);
      check("resp_req_ready", W'(req_ready_o), W'(0));
      check("resp_mem_req", W'(mem_req_o), W'(0));
      resp_ready = (k == rr_dly);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    check("resp_released", W'(resp_valid_o), W'(0));
    check("back_to_idle", W'(req_ready_o), W'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, W'(req_ready_o), W'(1));
    check({tag, "_mem_req"}, W'(mem_req_o), W'(0));
    check({tag, "_mem_addr"}, W'(mem_addr_o), W'(0));
    check({tag, "_mem_be"}, W'(mem_be_o), W'(0));
    check({tag, "_resp"}, W'({resp_valid_o, exc_valid_o, exc_code_o, resp_rd_data_o}), W'(0));
    check({tag, "_state"}, W'(dbg_state_o), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sz;
    logic [63:0] a;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Byte loads at 0x13: zero byte, then 0x80 signed and unsigned.
    run_txn(64'h13, 2'd0, 1'b0, 1'b0, '0, 64'h80FF0000_00000000, 1'b0, 0, 1, 0, 1'b0);
    run_txn(64'h13, 2'd0, 1'b0, 1'b0, '0, 64'h00000000_80000000, 1'b0, 0, 1, 0, 1'b0);
    run_txn(64'h13, 2'd0, 1'b1, 1'b0, '0, 64'h00000000_80000000, 1'b0, 0, 1, 0, 1'b0);
    // Half-word store into the top lanes of row 0x100.
    run_txn(64'h106, 2'd1, 1'b0, 1'b1, 64'hBEEF, 64'h1234, 1'b0, 0, 1, 0, 1'b0);
    // Misaligned load / store.
    run_txn(64'h2, 2'd2, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1, 0, 1'b0);
    run_txn(64'h7FFFC, 2'd3, 1'b0, 1'b1, 64'h55, '0, 1'b0, 0, 1, 0, 1'b0);
    // Bounds: last legal word, first illegal double word, wrapping store.
    run_txn(64'h7FFFC, 2'd2, 1'b0, 1'b0, '0, 64'h89ABCDEF_01234567, 1'b0, 0, 1, 0, 1'b0);
    run_txn(64'h80000, 2'd3, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1, 0, 1'b0);
    run_txn(64'hFFFFFFFF_FFFFFFF8, 2'd3, 1'b0, 1'b1, 64'h1, '0, 1'b0, 0, 1, 0, 1'b0);
    // Delayed grant, rvalid and response acceptance.
    run_txn(64'h1A8, 2'd3, 1'b0, 1'b0, '0, 64'hFEDCBA98_76543210, 1'b0, 3, 4, 2, 1'b0);
    run_txn(64'h2A4, 2'd2, 1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, '0, 1'b0, 2, 2, 1, 1'b0);
    // Watchdog and bus error.
    run_txn(64'h300, 2'd2, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1, 0, 1'b1);
    run_txn(64'h308, 2'd3, 1'b0, 1'b1, 64'h77, '0, 1'b1, 1, 2, 0, 1'b0);

    // Reset during WAIT abandons the transaction.
    req_valid = 1'b1; req_addr = 64'h40; req_size = 2'd2; req_wr = 1'b0; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("pre_reset_wait_state", W'(dbg_state_o), W'(2));
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    resetn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("stale_rvalid_ignored", W'({resp_valid_o, dbg_state_o}), W'(0));
    run_txn(64'h48, 2'd1, 1'b1, 1'b0, '0, 64'h0000_0000_8001_0000, 1'b0, 0, 1, 0, 1'b0);

    // Random mix within the legal region (may include misaligned requests).
    for (int t = 0; t < 12; t++) begin
      sz = $urandom_range(0, 3);
      a  = 64'($urandom_range(0, 32'h7FFFF));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      run_txn(a, 2'(sz), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom}, 1'b0,
              $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2), 1'b0);
    end

    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
